// File: rtl/fetch_predict_pkg.sv
// rtl/fetch_predict_pkg.sv - shared constants and counter helpers for the fetch/predict stage
package fetch_predict_pkg;

    localparam int          PC_W_DEF      = 5;
    localparam int          BTB_IDX_W_DEF = 3;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    // Two-bit saturating counter step toward the resolved outcome.
    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        ctr_e n;
        n = c;
        if (taken) begin
            if (c != ST) n = ctr_e'(c + 2'd1);
        end else begin
            if (c != SNT) n = ctr_e'(c - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_predict_btb_table.sv
// rtl/fetch_predict_btb_table.sv - direct-mapped branch target buffer, combinational lookup port plus one update port
module btb_table
    import fetch_predict_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int IDX_W = BTB_IDX_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] i_lk_pc,
    output logic            o_lk_taken,
    output logic [PC_W-1:0] o_lk_target,
    input  logic            i_upd_valid,
    input  logic [PC_W-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic [PC_W-1:0] i_upd_target
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [PC_W-1:0]  r_target [ENTRIES];
    ctr_e             r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;

    assign w_lk_idx  = i_lk_pc[IDX_W-1:0];
    assign w_lk_tag  = i_lk_pc[PC_W-1:IDX_W];
    assign w_upd_idx = i_upd_pc[IDX_W-1:0];
    assign w_upd_tag = i_upd_pc[PC_W-1:IDX_W];

    // Lookup reads the registered array, so a same-cycle update is seen one cycle later.
    assign w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign o_lk_taken  = w_lk_hit && (r_ctr[w_lk_idx] >= WT);
    assign o_lk_target = r_target[w_lk_idx];

    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= WNT;
            end
        end else if (i_upd_valid) begin
            if (w_upd_hit) begin
                r_ctr[w_upd_idx] <= ctr_next(r_ctr[w_upd_idx], i_upd_taken);
                if (i_upd_taken) r_target[w_upd_idx] <= i_upd_target;
            end else if (i_upd_taken) begin
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= i_upd_target;
                r_ctr[w_upd_idx]    <= WT;
            end
        end
    end

endmodule

// File: rtl/fetch_predict.sv
// rtl/fetch_predict.sv - fetch PC register with BTB-driven next-PC selection and the IF/ID pipeline register
module fetch_predict
    import fetch_predict_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int BTB_IDX_W = BTB_IDX_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    input  logic            IF_ID_write,
    input  logic            flush,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    output logic [31:0]     instruction_D,
    output logic [PC_W-1:0] Pc_D,
    output logic [PC_W-1:0] PcPlus1_D,
    output logic            prediction_D,
    output logic [PC_W-1:0] predTarget_D
);

    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [PC_W-1:0] r_pc_d;
    logic [PC_W-1:0] r_pc_plus1_d;
    logic            r_pred_d;
    logic [PC_W-1:0] r_pred_tgt_d;

    logic [PC_W-1:0] w_pc_plus1;
    logic            w_pred_taken;
    logic [PC_W-1:0] w_btb_target;
    logic [PC_W-1:0] w_pred_next;
    logic [PC_W-1:0] w_next_pc;
    logic            w_bubble;

    btb_table #(
        .PC_W  (PC_W),
        .IDX_W (BTB_IDX_W)
    ) u_btb (
        .clk          (clk),
        .reset        (reset),
        .i_lk_pc      (r_pc),
        .o_lk_taken   (w_pred_taken),
        .o_lk_target  (w_btb_target),
        .i_upd_valid  (upd_valid),
        .i_upd_pc     (upd_pc),
        .i_upd_taken  (upd_taken),
        .i_upd_target (upd_target)
    );

    assign w_pc_plus1 = r_pc + PC_W'(1);
    // predTarget_D carries the predicted next fetch PC, so EX compares one value either way.
    assign w_pred_next = w_pred_taken ? w_btb_target : w_pc_plus1;
    assign w_bubble    = flush || redirect_valid;

    always_comb begin
        w_next_pc = r_pc;
        if (redirect_valid)   w_next_pc = redirect_pc;
        else if (IF_ID_write) w_next_pc = w_pred_next;
    end

    always_ff @(posedge clk) begin
        if (reset) r_pc <= '0;
        else       r_pc <= w_next_pc;
    end

    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_instr      <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus1_d <= '0;
            r_pred_d     <= 1'b0;
            r_pred_tgt_d <= '0;
        end else if (IF_ID_write) begin
            r_instr      <= imem_data;
            r_pc_d       <= r_pc;
            r_pc_plus1_d <= w_pc_plus1;
            r_pred_d     <= w_pred_taken;
            r_pred_tgt_d <= w_pred_next;
        end
    end

    assign imem_addr     = r_pc;
    assign instruction_D = r_instr;
    assign Pc_D          = r_pc_d;
    assign PcPlus1_D     = r_pc_plus1_d;
    assign prediction_D  = r_pred_d;
    assign predTarget_D  = r_pred_tgt_d;

endmodule

// File: tb/tb_fetch_predict.sv
// tb/tb_fetch_predict.sv - self-checking bench for fetch_predict against a table-based reference model
module tb_fetch_predict;

    localparam int PC_W = 5;
    localparam int N    = 8;
    localparam int NPC  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic            IF_ID_write;
    logic            flush;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic [31:0]     instruction_D;
    logic [PC_W-1:0] Pc_D;
    logic [PC_W-1:0] PcPlus1_D;
    logic            prediction_D;
    logic [PC_W-1:0] predTarget_D;
    logic [31:0]     salt;

    always #5 clk = ~clk;

    assign imem_data = ({27'd0, imem_addr} << 4) ^ salt;

    fetch_predict dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .IF_ID_write    (IF_ID_write),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .instruction_D  (instruction_D),
        .Pc_D           (Pc_D),
        .PcPlus1_D      (PcPlus1_D),
        .prediction_D   (prediction_D),
        .predTarget_D   (predTarget_D)
    );

    int vectors = 0;
    int miscompares = 0;

    int          m_pc;
    int          m_v   [N];
    int          m_tag [N];
    int          m_tgt [N];
    int          m_ctr [N];
    logic [31:0] m_instr;
    int          m_pcd, m_pc1d, m_pred, m_ptgt;

    task automatic set_idle();
        reset = 1'b0; IF_ID_write = 1'b1; flush = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    endtask

    // Advance the reference model by one clock using the currently driven inputs, then clock the DUT.
    task automatic tick();
        int idx, hit, ptk, pc1, nxt, ui, uhit;
        idx = m_pc % N;
        hit = (m_v[idx] != 0) && (m_tag[idx] == m_pc / N);
        ptk = (hit != 0) && (m_ctr[idx] >= 2);
        pc1 = (m_pc + 1) % NPC;
        nxt = (ptk != 0) ? m_tgt[idx] : pc1;
        if (reset) begin
            m_pc = 0;
            m_instr = 32'd0; m_pcd = 0; m_pc1d = 0; m_pred = 0; m_ptgt = 0;
            for (int i = 0; i < N; i++) begin
                m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
            end
        end else begin
            if (flush || redirect_valid) begin
                m_instr = 32'd0; m_pcd = 0; m_pc1d = 0; m_pred = 0; m_ptgt = 0;
            end else if (IF_ID_write) begin
                m_instr = (32'(m_pc) * 32'd16) ^ salt;
                m_pcd = m_pc; m_pc1d = pc1; m_pred = ptk; m_ptgt = nxt;
            end
            if (redirect_valid)   m_pc = int'(redirect_pc);
            else if (IF_ID_write) m_pc = nxt;
            if (upd_valid) begin
                ui = int'(upd_pc) % N;
                uhit = (m_v[ui] != 0) && (m_tag[ui] == int'(upd_pc) / N);
                if (uhit != 0) begin
                    if (upd_taken) begin
                        if (m_ctr[ui] < 3) m_ctr[ui]++;
                        m_tgt[ui] = int'(upd_target);
                    end else if (m_ctr[ui] > 0) begin
                        m_ctr[ui]--;
                    end
                end else if (upd_taken) begin
                    m_v[ui] = 1; m_tag[ui] = int'(upd_pc) / N;
                    m_tgt[ui] = int'(upd_target); m_ctr[ui] = 2;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        salt = 32'd0;
        set_idle();
        reset = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 5'd9; flush = 1'b1; IF_ID_write = 1'b0;
        upd_valid = 1'b1; upd_pc = 5'd0; upd_taken = 1'b1; upd_target = 5'd7;
        tick();
        tick();
        set_idle();
        vectors++;
        if (imem_addr !== 5'd0) begin
            miscompares++; $display("FAIL reset_pc: got %0d want 0", imem_addr);
        end
        vectors++;
        if ({instruction_D, Pc_D, PcPlus1_D, prediction_D, predTarget_D} !== '0) begin
            miscompares++;
            $display("FAIL reset_ifid: got instr=%h pc=%0d pc1=%0d pred=%0d tgt=%0d want all 0",
                     instruction_D, Pc_D, PcPlus1_D, prediction_D, predTarget_D);
        end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (Pc_D !== 5'(k) || instruction_D !== 32'(k * 16) || prediction_D !== 1'b0 ||
                PcPlus1_D !== 5'(k + 1)) begin
                miscompares++;
                $display("FAIL seq_fetch_%0d: got pc=%0d instr=%h pred=%0d pc1=%0d want pc=%0d instr=%h pred=0 pc1=%0d",
                         k, Pc_D, instruction_D, prediction_D, PcPlus1_D, k, k * 16, k + 1);
            end
        end
        vectors++;
        if (imem_addr !== 5'd4) begin
            miscompares++; $display("FAIL seq_pc: got %0d want 4", imem_addr);
        end
    endtask

    task automatic test_predict_taken();
        upd_valid = 1'b1; upd_pc = 5'd5; upd_taken = 1'b1; upd_target = 5'd20;
        tick();
        set_idle();
        vectors++;
        if (imem_addr !== 5'd5) begin
            miscompares++; $display("FAIL taken_reach5: got %0d want 5", imem_addr);
        end
        tick();
        vectors++;
        if (Pc_D !== 5'd5 || prediction_D !== 1'b1 || predTarget_D !== 5'd20 || imem_addr !== 5'd20) begin
            miscompares++;
            $display("FAIL taken_pred: got pc=%0d pred=%0d tgt=%0d next=%0d want 5 1 20 20",
                     Pc_D, prediction_D, predTarget_D, imem_addr);
        end
    endtask

    task automatic test_not_taken();
        upd_valid = 1'b1; upd_pc = 5'd5; upd_taken = 1'b0;
        tick();
        tick();
        set_idle();
        redirect_valid = 1'b1; redirect_pc = 5'd5;
        tick();
        set_idle();
        vectors++;
        if (imem_addr !== 5'd5 || instruction_D !== 32'd0) begin
            miscompares++;
            $display("FAIL nt_redirect: got pc=%0d instr=%h want 5 0", imem_addr, instruction_D);
        end
        tick();
        vectors++;
        if (Pc_D !== 5'd5 || prediction_D !== 1'b0 || imem_addr !== 5'd6) begin
            miscompares++;
            $display("FAIL nt_pred: got pc=%0d pred=%0d next=%0d want 5 0 6", Pc_D, prediction_D, imem_addr);
        end
    endtask

    task automatic test_stall();
        tick();
        IF_ID_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (imem_addr !== 5'd7 || Pc_D !== 5'd6 || instruction_D !== 32'd96 || PcPlus1_D !== 5'd7) begin
                miscompares++;
                $display("FAIL stall_%0d: got addr=%0d pc=%0d instr=%h pc1=%0d want 7 6 60 7",
                         k, imem_addr, Pc_D, instruction_D, PcPlus1_D);
            end
        end
        flush = 1'b1;
        tick();
        vectors++;
        if (instruction_D !== 32'd0 || Pc_D !== 5'd0 || imem_addr !== 5'd7) begin
            miscompares++;
            $display("FAIL stall_flush: got instr=%h pc=%0d addr=%0d want 0 0 7", instruction_D, Pc_D, imem_addr);
        end
        set_idle();
    endtask

    task automatic test_redirect();
        IF_ID_write = 1'b0; redirect_valid = 1'b1; redirect_pc = 5'd12;
        tick();
        set_idle();
        vectors++;
        if (imem_addr !== 5'd12 || instruction_D !== 32'd0) begin
            miscompares++;
            $display("FAIL redirect: got addr=%0d instr=%h want 12 0", imem_addr, instruction_D);
        end
        tick();
        vectors++;
        if (Pc_D !== 5'd12 || instruction_D !== 32'd192 || imem_addr !== 5'd13) begin
            miscompares++;
            $display("FAIL redirect_fetch: got pc=%0d instr=%h addr=%0d want 12 c0 13", Pc_D, instruction_D, imem_addr);
        end
    endtask

    task automatic test_same_cycle();
        redirect_valid = 1'b1; redirect_pc = 5'd3;
        tick();
        set_idle();
        upd_valid = 1'b1; upd_pc = 5'd3; upd_taken = 1'b1; upd_target = 5'd25;
        tick();
        vectors++;
        if (Pc_D !== 5'd3 || prediction_D !== 1'b0 || imem_addr !== 5'd4) begin
            miscompares++;
            $display("FAIL same_cycle_lookup: got pc=%0d pred=%0d addr=%0d want 3 0 4", Pc_D, prediction_D, imem_addr);
        end
        redirect_valid = 1'b1; redirect_pc = 5'd3;
        tick();
        set_idle();
        vectors++;
        if (imem_addr !== 5'd3) begin
            miscompares++; $display("FAIL upd_with_redirect: got %0d want 3", imem_addr);
        end
        tick();
        vectors++;
        if (prediction_D !== 1'b1 || predTarget_D !== 5'd25 || imem_addr !== 5'd25) begin
            miscompares++;
            $display("FAIL upd_then_hit: got pred=%0d tgt=%0d addr=%0d want 1 25 25", prediction_D, predTarget_D, imem_addr);
        end
    endtask

    task automatic test_wrap_and_reset();
        redirect_valid = 1'b1; redirect_pc = 5'd31;
        tick();
        set_idle();
        tick();
        vectors++;
        if (Pc_D !== 5'd31 || PcPlus1_D !== 5'd0 || imem_addr !== 5'd0 || prediction_D !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap: got pc=%0d pc1=%0d addr=%0d pred=%0d want 31 0 0 0", Pc_D, PcPlus1_D, imem_addr, prediction_D);
        end
        upd_valid = 1'b1; upd_pc = 5'd9; upd_taken = 1'b1; upd_target = 5'd3;
        redirect_valid = 1'b1; redirect_pc = 5'd9;
        tick();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (imem_addr !== 5'd0 || Pc_D !== 5'd0) begin
            miscompares++; $display("FAIL reset_mid: got addr=%0d pc=%0d want 0 0", imem_addr, Pc_D);
        end
        redirect_valid = 1'b1; redirect_pc = 5'd9;
        tick();
        set_idle();
        tick();
        vectors++;
        if (Pc_D !== 5'd9 || prediction_D !== 1'b0 || imem_addr !== 5'd10) begin
            miscompares++;
            $display("FAIL reset_history: got pc=%0d pred=%0d addr=%0d want 9 0 10", Pc_D, prediction_D, imem_addr);
        end
    endtask

    task automatic test_random();
        salt = $urandom;
        for (int c = 0; c < 800; c++) begin
            reset          = ($urandom_range(0, 63) == 0);
            IF_ID_write    = ($urandom_range(0, 9) < 8);
            flush          = ($urandom_range(0, 9) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 5'($urandom_range(0, 31));
            upd_valid      = ($urandom_range(0, 1) == 1);
            upd_pc         = 5'($urandom_range(0, 31));
            upd_taken      = ($urandom_range(0, 9) < 7);
            upd_target     = 5'($urandom_range(0, 31));
            tick();
            vectors++;
            if (imem_addr !== 5'(m_pc)) begin
                miscompares++; $display("FAIL rnd_pc[%0d]: got %0d want %0d", c, imem_addr, m_pc);
            end
            vectors++;
            if (instruction_D !== m_instr) begin
                miscompares++; $display("FAIL rnd_instr[%0d]: got %h want %h", c, instruction_D, m_instr);
            end
            vectors++;
            if (Pc_D !== 5'(m_pcd) || PcPlus1_D !== 5'(m_pc1d)) begin
                miscompares++;
                $display("FAIL rnd_pcd[%0d]: got %0d/%0d want %0d/%0d", c, Pc_D, PcPlus1_D, m_pcd, m_pc1d);
            end
            vectors++;
            if (prediction_D !== 1'(m_pred) || predTarget_D !== 5'(m_ptgt)) begin
                miscompares++;
                $display("FAIL rnd_pred[%0d]: got %0d/%0d want %0d/%0d", c, prediction_D, predTarget_D, m_pred, m_ptgt);
            end
        end
        set_idle();
        salt = 32'd0;
    endtask

    initial begin
        m_pc = 0;
        m_instr = 32'd0; m_pcd = 0; m_pc1d = 0; m_pred = 0; m_ptgt = 0;
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        salt = 32'd0;
        set_idle();
        #1;
        test_reset();
        test_sequential();
        test_predict_taken();
        test_not_taken();
        test_stall();
        test_redirect();
        test_same_cycle();
        test_wrap_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_predict.md
FETCH_PREDICT -- requirements
Module: fetch_predict

Interface
REQ-001 Parameters: PC_W, 5, instruction-word PC width.
REQ-002 Parameters: BTB_IDX_W, 3, BTB index width (8 entries); tag width = PC_W-BTB_IDX_W.
REQ-003 Ports, in order:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imem_addr  out  PC_W  current PC to instruction memory (combinational-read).
- imem_data  in  32  instruction at imem_addr, same cycle.
- IF_ID_write  in  1  0 = hold PC and IF/ID register (stall from hazard unit).
- flush  in  1  1 = load bubble into IF/ID.
- redirect_valid  in  1  mispredict/JR correction from EX.
- redirect_pc  in  PC_W  corrected fetch PC.
- upd_valid  in  1  resolved branch in EX.
- upd_pc  in  PC_W  PC of resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_W  actual taken target.
- instruction_D  out  32  IF/ID instruction.
- Pc_D  out  PC_W  IF/ID PC.
- PcPlus1_D  out  PC_W  IF/ID PC+1.
- prediction_D  out  1  taken prediction made for Pc_D.
- predTarget_D  out  PC_W  predicted target for Pc_D.

Function
REQ-004 BTB SHALL hold per entry: valid, tag, target (PC_W), 2-bit saturating counter, indexed by pc[BTB_IDX_W-1:0].
REQ-005 Lookup SHALL be combinational on current PC: hit = valid and tag match; predict taken = hit and counter >= 2.
REQ-006 Next PC priority SHALL be: redirect_valid -> redirect_pc; else IF_ID_write=0 -> hold; else predict taken -> BTB target; else PC+1.
REQ-007 PC+1 SHALL wrap modulo 2^PC_W (31 -> 0 for default).
REQ-008 IF/ID SHALL capture {imem_data, PC, PC+1, prediction, target} one cycle after PC is presented, when IF_ID_write=1 and no flush/redirect.
REQ-009 flush=1 or redirect_valid=1 SHALL load bubble: instruction_D=0, prediction_D=0, Pc_D/PcPlus1_D/predTarget_D=0; this overrides IF_ID_write=0.
REQ-010 IF_ID_write=0 with no flush/redirect SHALL hold all IF/ID outputs unchanged.
REQ-011 Update on hit (upd_valid): counter +1 saturating at 3 if taken, -1 saturating at 0 if not; target overwritten with upd_target when taken.
REQ-012 Update on miss: taken -> allocate (valid=1, tag, target, counter=2); not taken -> no change.
REQ-013 BTB updates SHALL be unaffected by IF_ID_write and flush.
REQ-014 Same-cycle lookup and update of one index: lookup SHALL see pre-update contents; new contents visible next cycle.
REQ-015 upd_valid and redirect_valid in same cycle SHALL both take effect.

Reset
REQ-016 reset=1 at clock edge: PC=0, IF/ID = bubble (all outputs 0), all BTB valid=0, counters=1, tags/targets=0.
REQ-017 reset SHALL override redirect, stall, flush and update in that cycle; first fetch after release from PC 0.
REQ-018 Reset mid-operation SHALL discard all predictor history.

Structure
REQ-019 Shared package SHALL hold PC_W default, NOP encoding (32'h0), counter constants (SNT=0, WNT=1, WT=2, ST=3).
REQ-020 BTB SHALL be sub-module btb_table (lookup port + update port); PC and IF/ID registers in fetch_predict.

Verification
REQ-021 Reset, then 4 cycles IF_ID_write=1, imem_data=PC*16 -> Pc_D 0,1,2,3; instruction_D 0x00,0x10,0x20,0x30; prediction_D=0.
REQ-022 upd_valid, upd_pc=5, upd_taken=1, upd_target=20 -> next fetch of PC 5: prediction_D=1, following imem_addr=20.
REQ-023 Two not-taken updates at PC 5 after REQ-022 -> counter 0; fetch of 5 predicts not-taken, next PC 6.
REQ-024 IF_ID_write=0 for 3 cycles at PC 7 -> imem_addr stays 7, IF/ID outputs frozen; flush=1 during stall -> instruction_D=0.
REQ-025 redirect_valid=1, redirect_pc=12 with IF_ID_write=0 -> next imem_addr=12, instruction_D=0.
REQ-026 PC=31, no prediction -> next imem_addr=0; reset asserted at PC 9 with BTB hit -> PC=0, hit lost.
